uart_rx_cmd: RTL and testbench

8N1 UART receiver with 16x oversampling that deserializes the serial command line into bytes for the command FSM's idata input. It decodes start, data and stop bits, flags framing errors and pulses a one-cycle valid strobe per good byte. Baud rate is selected by the same ASCII rate code the command FSM produces ('1', '5', 'A'), so one rate byte configures both directions of the link.

---
 rtl/uart_rx_cmd.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_cmd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cmd
// Brief    : 8N1 UART receiver, 16x oversampled, baud set by ASCII rate code.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cmd #(
    parameter int DIV_1 = 27,
    parameter int DIV_5 = 54,
    parameter int DIV_A = 325
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iRX,
    input  logic [7:0] iRX_rate,
    output logic [7:0] oRX_data,
    output logic       oRX_valid,
    output logic       oFRAME_ERR,
    output logic       oRX_busy
);

    localparam int DIV_MAX_15 = (DIV_1 > DIV_5) ? DIV_1 : DIV_5;
    localparam int DIV_MAX    = (DIV_MAX_15 > DIV_A) ? DIV_MAX_15 : DIV_A;
    localparam int DW         = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);

    // Divisors are held as terminal count (DIV-1) so the counter compares directly.
    localparam logic [DW-1:0] TC_1 = DW'(DIV_1 - 1);
    localparam logic [DW-1:0] TC_5 = DW'(DIV_5 - 1);
    localparam logic [DW-1:0] TC_A = DW'(DIV_A - 1);
    localparam logic [DW-1:0] ONE  = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [DW-1:0] div_tc;
    logic [DW-1:0] rate_tc;
    logic [DW-1:0] tcnt;
    logic [3:0]    os;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic          tick;
    logic          mid_tick;
    logic          end_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= iRX;
            rx_s    <= rx_meta;
        end
    end

    // Unknown rate codes keep whatever divisor was latched last.
    always_comb begin
        rate_tc = div_tc;
        case (iRX_rate)
            8'h31:   rate_tc = TC_1;
            8'h35:   rate_tc = TC_5;
            8'h41:   rate_tc = TC_A;
            default: rate_tc = div_tc;
        endcase
    end

    assign tick     = (state != S_IDLE) && (tcnt == div_tc);
    assign mid_tick = tick && (os == 4'd7);
    assign end_tick = tick && (os == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_tc     <= TC_1;
            tcnt       <= '0;
            os         <= 4'd0;
            bitn       <= 3'd0;
            shreg      <= 8'h00;
            oRX_data   <= 8'h00;
            oRX_valid  <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oRX_busy   <= 1'b0;
        end else begin
            oRX_valid  <= 1'b0;
            oFRAME_ERR <= 1'b0;

            if (tick) begin
                tcnt <= '0;
                os   <= os + 4'd1;
            end else if (state != S_IDLE) begin
                tcnt <= tcnt + ONE;
            end

            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    os   <= 4'd0;
                    if (!rx_s) begin
                        state    <= S_START;
                        div_tc   <= rate_tc;
                        oRX_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (mid_tick) begin
                        os <= 4'd0;
                        if (!rx_s) begin
                            state <= S_DATA;
                            bitn  <= 3'd0;
                        end else begin
                            state    <= S_IDLE;
                            oRX_busy <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (end_tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (end_tick) begin
                        if (rx_s) begin
                            oRX_data  <= shreg;
                            oRX_valid <= 1'b1;
                            oRX_busy  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            oFRAME_ERR <= 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                end
                // A stuck-low line parks here so it cannot spawn back-to-back frames.
                S_WAIT: begin
                    if (rx_s) begin
                        state    <= S_IDLE;
                        oRX_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    oRX_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cmd
// Brief    : Directed bench for uart_rx_cmd with a queue-based output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd;

    localparam int B1 = 64;
    localparam int B5 = 32;
    localparam int BA = 16;
    localparam int EVT_NONE  = 0;
    localparam int EVT_RATE  = 1;
    localparam int EVT_RESET = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       iRX;
    logic [7:0] iRX_rate;
    logic [7:0] oRX_data;
    logic       oRX_valid;
    logic       oFRAME_ERR;
    logic       oRX_busy;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    uart_rx_cmd #(.DIV_1(4), .DIV_5(2), .DIV_A(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .iRX        (iRX),
        .iRX_rate   (iRX_rate),
        .oRX_data   (oRX_data),
        .oRX_valid  (oRX_valid),
        .oFRAME_ERR (oFRAME_ERR),
        .oRX_busy   (oRX_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every valid or frame-error pulse must match the queue head.
    always @(negedge clk) begin
        if (oRX_valid && oFRAME_ERR) begin
            chk("valid_and_ferr", 16'd1, 16'd0);
        end else if (oRX_valid || oFRAME_ERR) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {7'd0, oFRAME_ERR, oRX_data}, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rx_out", {7'd0, oFRAME_ERR, oRX_data}, {7'd0, e.ferr, e.data});
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop,
                              input int evt_bit, input int evt_kind);
        iRX = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            iRX = d[i];
            if (i == evt_bit && evt_kind == EVT_RATE) iRX_rate = 8'h41;
            repeat (bclk / 2) @(negedge clk);
            if (i == 0) chk("busy_mid", {15'd0, oRX_busy}, 16'd1);
            if (i == evt_bit && evt_kind == EVT_RESET) begin
                reset = 1'b0;
                #1;
                chk("abort_data",  {8'd0, oRX_data}, 16'h0000);
                chk("abort_valid", {15'd0, oRX_valid}, 16'd0);
                chk("abort_ferr",  {15'd0, oFRAME_ERR}, 16'd0);
                chk("abort_busy",  {15'd0, oRX_busy}, 16'd0);
                iRX = 1'b1;
                return;
            end
            repeat (bclk - bclk / 2) @(negedge clk);
        end
        iRX = stop;
        repeat (bclk) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dev;
        int waited;
        reset    = 1'b0;
        iRX      = 1'b1;
        iRX_rate = 8'h31;
        repeat (3) @(negedge clk);

        // Reset state and quiet idle line
        chk("rst_data",  {8'd0, oRX_data}, 16'h0000);
        chk("rst_valid", {15'd0, oRX_valid}, 16'd0);
        chk("rst_ferr",  {15'd0, oFRAME_ERR}, 16'd0);
        chk("rst_busy",  {15'd0, oRX_busy}, 16'd0);
        reset = 1'b1;
        dev = 0;
        repeat (200) begin
            @(negedge clk);
            if ({oRX_data, oRX_valid, oFRAME_ERR, oRX_busy} !== 11'd0) dev++;
        end
        chk("idle_200", dev[15:0], 16'd0);

        // Single byte at rate '1'
        exp_q.push_back('{ferr: 1'b0, data: 8'h4D});
        send_frame(8'h4D, B1, 1'b1, -1, EVT_NONE);
        chk("busy_after_stop", {15'd0, oRX_busy}, 16'd0);
        repeat (20) @(negedge clk);

        // Start-bit glitch
        iRX = 1'b0;
        repeat (12) @(negedge clk);
        iRX = 1'b1;
        waited = 0;
        while (oRX_busy && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        chk("glitch_busy", {15'd0, oRX_busy}, 16'd0);
        repeat (40) @(negedge clk);

        // Framing error followed by a stuck-low line
        exp_q.push_back('{ferr: 1'b1, data: 8'h4D});
        send_frame(8'h66, B1, 1'b0, -1, EVT_NONE);
        dev = 0;
        repeat (3 * B1) begin
            @(negedge clk);
            if (oRX_busy !== 1'b1) dev++;
        end
        chk("wait_busy_hold", dev[15:0], 16'd0);
        iRX = 1'b1;
        waited = 0;
        while (oRX_busy && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_release", {15'd0, oRX_busy}, 16'd0);
        chk("data_kept", {8'd0, oRX_data}, 16'h004D);
        repeat (40) @(negedge clk);

        // Rate change during data bit 3 applies only to the following frame
        exp_q.push_back('{ferr: 1'b0, data: 8'h46});
        send_frame(8'h46, B1, 1'b1, 3, EVT_RATE);
        repeat (10) @(negedge clk);
        exp_q.push_back('{ferr: 1'b0, data: 8'h41});
        send_frame(8'h41, BA, 1'b1, -1, EVT_NONE);
        repeat (20) @(negedge clk);

        // Back-to-back frames at rate '5', then reset mid-frame
        iRX_rate = 8'h35;
        exp_q.push_back('{ferr: 1'b0, data: 8'h31});
        send_frame(8'h31, B5, 1'b1, -1, EVT_NONE);
        exp_q.push_back('{ferr: 1'b0, data: 8'h35});
        send_frame(8'h35, B5, 1'b1, -1, EVT_NONE);
        send_frame(8'h5A, B5, 1'b1, 4, EVT_RESET);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        exp_q.push_back('{ferr: 1'b0, data: 8'hA5});
        send_frame(8'hA5, B5, 1'b1, -1, EVT_NONE);
        repeat (40) @(negedge clk);

        chk("queue_empty", exp_q.size(), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
